// File: rtl/apb_system_if.sv
// Request/response bundle between a command source and apb_system.
// master drives requests; slave (apb_system) returns read data.
interface apb_system_if;
    logic        read_i;
    logic        write_i;
    logic        rd_valid_o;
    logic [31:0] rd_data_o;

    modport master (
        output read_i,
        output write_i,
        input  rd_valid_o,
        input  rd_data_o
    );

    modport slave (
        input  read_i,
        input  write_i,
        output rd_valid_o,
        output rd_data_o
    );
endinterface

// File: rtl/apb_system.sv
// APB subsystem: pending-request counters, arbiter, APB master FSM and an internal register file.
// Define APB_RR_ARB_EN for round-robin arbitration; otherwise reads have fixed priority.
module apb_system #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned DEPTH       = 8
) (
    input logic         clk,
    input logic         reset,
    apb_system_if.slave req
);
    // DEPTH is a power of two, at least 2.
    localparam int unsigned AddrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WaitLast = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e           state_q, state_d;
    logic [3:0]       rd_pend_q, rd_pend_d;
    logic [3:0]       wr_pend_q, wr_pend_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] paddr_q, paddr_d;
    logic             pwrite_q, pwrite_d;
    logic [31:0]      pwdata_q, pwdata_d;
    logic [31:0]      last_rd_q, last_rd_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic [3:0]       wait_q, wait_d;
    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];

    logic        psel, penable, pready;
    logic [31:0] prdata;
    logic        gnt_rd, gnt_wr;
    logic        both_pick_wr;

    function automatic logic [3:0] pend_next(logic [3:0] cnt, logic req_in, logic gnt);
        if (req_in && !gnt) return (cnt == 4'hF) ? cnt : cnt + 4'd1;
        if (!req_in && gnt) return cnt - 4'd1;
        return cnt;
    endfunction

`ifdef APB_RR_ARB_EN
    // last_wr_q = 1 means the last grant was a write, so a read goes next.
    logic last_wr_q, last_wr_d;

    assign both_pick_wr = ~last_wr_q;

    always_comb begin
        last_wr_d = last_wr_q;
        if (gnt_rd) begin
            last_wr_d = 1'b0;
        end else if (gnt_wr) begin
            last_wr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_wr_q <= 1'b1;
        end else begin
            last_wr_q <= last_wr_d;
        end
    end
`else
    assign both_pick_wr = 1'b0;
`endif

    always_comb begin
        gnt_rd = 1'b0;
        gnt_wr = 1'b0;
        if (state_q == StIdle) begin
            if (rd_pend_q != 4'd0 && wr_pend_q != 4'd0) begin
                gnt_wr = both_pick_wr;
                gnt_rd = ~both_pick_wr;
            end else begin
                gnt_rd = (rd_pend_q != 4'd0);
                gnt_wr = (wr_pend_q != 4'd0);
            end
        end
    end

    assign rd_pend_d = pend_next(rd_pend_q, req.read_i, gnt_rd);
    assign wr_pend_d = pend_next(wr_pend_q, req.write_i, gnt_wr);

    // Peripheral side: pready on the (WAIT_STATES+1)th ACCESS cycle.
    assign psel    = (state_q != StIdle);
    assign penable = (state_q == StAccess);
    assign pready  = psel && penable && (wait_q == WaitLast);
    assign prdata  = mem_q[paddr_q];
    assign wait_d  = (penable && !pready) ? wait_q + 4'd1 : 4'd0;

    always_comb begin
        mem_d = mem_q;
        if (pready && pwrite_q) begin
            mem_d[paddr_q] = pwdata_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        last_rd_d  = last_rd_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gnt_rd || gnt_wr) begin
                    state_d  = StSetup;
                    paddr_d  = gnt_wr ? wr_ptr_q : rd_ptr_q;
                    pwrite_d = gnt_wr;
                    pwdata_d = last_rd_q + 32'd1;
                end
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                if (pready) begin
                    state_d = StIdle;
                    if (pwrite_q) begin
                        wr_ptr_d = wr_ptr_q + AddrW'(1);
                    end else begin
                        rd_ptr_d   = rd_ptr_q + AddrW'(1);
                        rd_data_d  = prdata;
                        last_rd_d  = prdata;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            rd_pend_q  <= 4'd0;
            wr_pend_q  <= 4'd0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= 32'd0;
            last_rd_q  <= 32'd0;
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
            wait_q     <= 4'd0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            wr_pend_q  <= wr_pend_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            last_rd_q  <= last_rd_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wait_q     <= wait_d;
            mem_q      <= mem_d;
        end
    end

    assign req.rd_valid_o = rd_valid_q;
    assign req.rd_data_o  = rd_data_q;
endmodule

// File: tb/tb_apb_system.sv
// Self-checking bench for apb_system: scoreboard of expected read data plus timing/count checks.
// Arbitration test follows APB_RR_ARB_EN.
module tb_apb_system;
    logic clk = 1'b0;
    logic rst_n;
    logic sat_rst_n;

    always #5 clk = ~clk;

    apb_system_if bus ();
    apb_system_if sat_bus ();

    apb_system #(.WAIT_STATES(1), .DEPTH(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .req   (bus)
    );

    apb_system #(.WAIT_STATES(15), .DEPTH(8)) dut_sat (
        .clk   (clk),
        .reset (sat_rst_n),
        .req   (sat_bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pulses = 0;
    int sat_pulses = 0;
    int last_pulse_cyc = 0;
    bit zero_mode = 1'b0;

    logic [31:0] exp_q[$];
    logic [31:0] m_mem [8];
    int          m_rd_ptr;
    int          m_wr_ptr;
    logic [31:0] m_last_rd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] exp_v;
        if (rst_n === 1'b1 && bus.rd_valid_o === 1'b1) begin
            pulses++;
            last_pulse_cyc = cyc;
            if (zero_mode) begin
                check_eq("starve_rd_data", bus.rd_data_o, 32'd0);
            end else if (exp_q.size() == 0) begin
                check_eq("unexpected_rd_valid", 32'(bus.rd_valid_o), 32'd0);
            end else begin
                exp_v = exp_q.pop_front();
                check_eq("rd_data", bus.rd_data_o, exp_v);
            end
        end
        if (sat_rst_n === 1'b1 && sat_bus.rd_valid_o === 1'b1) begin
            sat_pulses++;
            check_eq("sat_rd_data", sat_bus.rd_data_o, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 32'd0;
        m_rd_ptr  = 0;
        m_wr_ptr  = 0;
        m_last_rd = 32'd0;
        exp_q.delete();
        pulses = 0;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic model_read();
        exp_q.push_back(m_mem[m_rd_ptr]);
        m_last_rd = m_mem[m_rd_ptr];
        m_rd_ptr  = (m_rd_ptr + 1) % 8;
    endtask

    task automatic model_write();
        m_mem[m_wr_ptr] = m_last_rd + 32'd1;
        m_wr_ptr        = (m_wr_ptr + 1) % 8;
    endtask

    task automatic pulse_read();
        model_read();
        bus.read_i = 1'b1;
        step();
        bus.read_i = 1'b0;
    endtask

    task automatic pulse_write();
        model_write();
        bus.write_i = 1'b1;
        step();
        bus.write_i = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            check_eq({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (4) step();
    endtask

    initial begin
        int c0;
        rst_n           = 1'b0;
        sat_rst_n       = 1'b0;
        sat_bus.read_i  = 1'b0;
        sat_bus.write_i = 1'b0;
        model_reset();

        // Reset with requests asserted: outputs stay zero, requests ignored.
        bus.read_i  = 1'b1;
        bus.write_i = 1'b1;
        step();
        check_eq("rst_valid_0", 32'(bus.rd_valid_o), 32'd0);
        check_eq("rst_data_0", bus.rd_data_o, 32'd0);
        step();
        check_eq("rst_valid_1", 32'(bus.rd_valid_o), 32'd0);
        check_eq("rst_data_1", bus.rd_data_o, 32'd0);
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        rst_n       = 1'b1;
        repeat (20) step();
        check_eq("idle_no_xfer", 32'(pulses), 32'd0);
        check_eq("idle_data", bus.rd_data_o, 32'd0);

        // Single read latency: rd_valid_o in cycle 5.
        c0 = cyc;
        pulse_read();
        drain("single", 40);
        check_eq("single_latency", 32'(last_pulse_cyc - c0), 32'd5);
        check_eq("single_pulse_cnt", 32'(pulses), 32'd1);

        // Write then read, twice.
        do_reset();
        pulse_write();
        repeat (8) step();
        pulse_read();
        drain("wr_rd1", 40);
        check_eq("wr_rd1_data", bus.rd_data_o, 32'd1);
        pulse_write();
        repeat (8) step();
        pulse_read();
        drain("wr_rd2", 40);
        check_eq("wr_rd2_data", bus.rd_data_o, 32'd2);
        check_eq("wr_rd_pulses", 32'(pulses), 32'd2);

        // Reset during ACCESS aborts the write.
        do_reset();
        bus.write_i = 1'b1;
        step();
        bus.write_i = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
        repeat (6) step();
        check_eq("abort_no_valid", 32'(pulses), 32'd0);
        pulse_read();
        drain("abort", 40);
        check_eq("abort_reg0", bus.rd_data_o, 32'd0);

`ifdef APB_RR_ARB_EN
        // Simultaneous request: read first, then write stores 1 in register 0.
        do_reset();
        model_read();
        model_write();
        bus.read_i  = 1'b1;
        bus.write_i = 1'b1;
        step();
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        drain("rr_first", 40);
        repeat (8) step();
        for (int i = 0; i < 8; i++) begin
            pulse_read();
            drain("rr_scan", 40);
        end
        check_eq("rr_reg0", bus.rd_data_o, 32'd1);
`else
        // Fixed priority: with reads always pending the write never runs.
        do_reset();
        zero_mode   = 1'b1;
        bus.read_i  = 1'b1;
        bus.write_i = 1'b1;
        step();
        bus.write_i = 1'b0;
        repeat (80) step();
        bus.read_i = 1'b0;
        repeat (80) step();
        zero_mode = 1'b0;
        check_eq("starve_pulses_ge10", 32'(pulses >= 10), 32'd1);
`endif

        // Pointer wrap: 8 writes then 9 reads.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pulse_write();
            repeat (6) step();
        end
        for (int i = 0; i < 9; i++) begin
            pulse_read();
            drain("wrap", 40);
        end
        check_eq("wrap_pulses", 32'(pulses), 32'd9);
        check_eq("wrap_last", bus.rd_data_o, 32'd1);

        // Saturation with WAIT_STATES = 15: 18 request cycles yield 16 reads.
        step();
        sat_rst_n  = 1'b1;
        sat_pulses = 0;
        step();
        sat_bus.read_i = 1'b1;
        repeat (18) step();
        sat_bus.read_i = 1'b0;
        repeat (16 * 18 + 40) step();
        check_eq("sat_pulse_cnt", 32'(sat_pulses), 32'd16);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/apb_system.md
# apb_system

Self-contained APB subsystem: a request front end that queues single-cycle read/write requests, an arbiter, an APB master FSM, and an internal APB register-file peripheral. Each granted read performs an APB read and returns the data on `rd_data_o` with a one-cycle `rd_valid_o` pulse. Each granted write stores (last read data + 1) into the peripheral. It sits between a simple command source and the on-chip peripheral bus model.

## Interface
- `WAIT_STATES`, default 1: extra ACCESS cycles the peripheral inserts before `pready`. Range 0..15.
- `DEPTH`, default 8: peripheral register-file depth in 32-bit words. Must be a power of two.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `read_i` in 1: read request, sampled every cycle; each high cycle is one request.
- `write_i` in 1: write request, sampled every cycle; each high cycle is one request.
- `rd_valid_o` out 1: one-cycle pulse when read data is returned.
- `rd_data_o` out 32: data of the most recent completed read; held between reads.

## Operation
- Pending counters:
  - Two 4-bit counters, `rd_pend` and `wr_pend`, count outstanding requests and saturate at 15. Requests beyond 15 are dropped.
  - On a cycle with both a request and a grant of the same type, the counter is unchanged.
- Arbiter, evaluated only when the master is in IDLE:
  - Grants if the pending count is nonzero.
  - If exactly one type is pending, that type is granted.
  - If both are pending, the rule depends on the configuration macro.
  - A grant decrements the corresponding counter at that edge.
- Master FSM, states IDLE, SETUP, ACCESS:
  - IDLE → SETUP on grant.
  - SETUP → ACCESS unconditionally.
  - ACCESS stays in ACCESS while `pready` = 0 and goes to IDLE when `pready` = 1.
  - `psel` is high in SETUP and ACCESS; `penable` is high in ACCESS only.
  - `paddr`, `pwrite` and `pwdata` are held stable from SETUP through ACCESS.
- Addressing:
  - Separate `rd_ptr` and `wr_ptr`, each log2(DEPTH) bits, reset to 0.
  - The relevant pointer increments on completion of its transfer and wraps DEPTH-1 → 0.
- Write data: `pwdata` = `last_rd` + 1, taken modulo 2^32 (0xFFFF_FFFF + 1 = 0). `last_rd` resets to 0.
- Peripheral:
  - DEPTH×32 register array, reset to 0.
  - In ACCESS it asserts `pready` on the (WAIT_STATES+1)th ACCESS cycle.
  - Writes commit on the `pready` edge; `prdata` is valid with `pready`.
  - No `pslverr`.
- Read completion: on the edge ending an ACCESS cycle with `pready` = 1:
  - `rd_data_o` and `last_rd` take `prdata`.
  - `rd_valid_o` = 1 for the next cycle only.
  - Write completion never asserts `rd_valid_o`.

## Timing
- Reset values: `rd_valid_o` = 0, `rd_data_o` = 0. Reset also forces FSM = IDLE, both counters = 0, both pointers = 0, `last_rd` = 0, registers = 0, arbiter state = "read next".
- Request-to-data latency with an idle master:
  - `read_i` high in cycle 0; count visible in cycle 1 (IDLE, grant).
  - SETUP in cycle 2; ACCESS in cycles 3..3+W.
  - `rd_valid_o` high in cycle 4+W (cycle 5 at the default W = 1).
- Throughput: one transfer per 3+W cycles, since IDLE is always visited between transfers.
- Reset asserted mid-transfer aborts the transfer next edge: no write commit, no `rd_valid_o`, pending requests lost.
- Requests sampled during reset are ignored.

## Configuration
- `APB_RR_ARB_EN` defined: round-robin arbitration.
  - When both types are pending, the grant goes to the type not granted last.
  - After reset, read wins first.
  - A single-type grant also updates the "last granted" state.
- `APB_RR_ARB_EN` undefined: fixed priority, read always wins when both are pending. Writes can starve.

## Test plan
- Reset: hold `reset` = 0 for 2 cycles with `read_i` = `write_i` = 1 → `rd_valid_o` = 0 and `rd_data_o` = 0 throughout. No transfer starts after release until new requests arrive.
- Single read, W = 1: `read_i` pulse in cycle 0 → `rd_valid_o` high only in cycle 5 with `rd_data_o` = 0.
- Write then read:
  - Stimulus: `write_i` pulse, transfer done, then `read_i` pulse.
  - Required: register 0 = 1; `rd_data_o` = 0x0000_0001.
  - A second write/read pair then writes and reads register 1 = 2.
- Simultaneous request with `APB_RR_ARB_EN` defined: `read_i` = `write_i` = 1 for one cycle from reset → read completes first (`rd_data_o` = 0), then write stores 1 to register 0.
- Same simultaneous-request stimulus without the macro, plus `read_i` held high continuously → no write transfer ever occurs.
- Saturation, WAIT_STATES = 15: `read_i` high for 18 consecutive cycles from idle → exactly 16 `rd_valid_o` pulses in total.
- Wrap, DEPTH = 8: 8 write pulses, then 9 read pulses → all reads return 1, with the 9th read returning register 0.
